sp_mem_req_ctrl: RTL

- Request/response front-end sitting directly upstream of the single-port SRAM wrapper (en_i/addr_i/wdata_i/we_i/be_i/ram_rdata_o).
- Converts a PULP-style req/gnt + rvalid/rready interface into SRAM strobes, tracks the fixed 1-cycle SRAM read latency, and buffers responses in a 2-entry fall-through FIFO so the master may back-pressure.
- Writes also return a response beat (write ack).

---
 rtl/sp_mem_req_ctrl_if.sv | 26 ++
 rtl/sp_mem_req_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sp_mem_req_ctrl_if.sv
// Request/response bus between a PULP-style master and the single-port SRAM front-end.
// Carries the req/gnt request channel and the rvalid/rready response channel.
interface sp_mem_req_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic            req;
    logic            gnt;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   wdata;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;

    modport master (
        output req, we, addr, be, wdata, rready,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata, rready,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sp_mem_req_ctrl.sv
// Front-end for a 1-cycle-latency single-port SRAM: req/gnt in, rvalid/rready out, 2-entry response FIFO.
// Optional power-up clear sweep of the whole SRAM is enabled with the SP_MEM_INIT_EN macro.
module sp_mem_req_ctrl #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    sp_mem_req_ctrl_if.slave bus,
    output logic            init_busy_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i
);

    localparam int BW = DW / 8;

    logic          pending;
    logic          pend_rd;
    logic [DW-1:0] fifo_q [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    occ;

    logic          grant;
    logic          credit_ok;
    logic          fifo_nonempty;
    logic          fifo_pop;
    logic          fifo_push;
    logic [DW-1:0] resp_data;

    logic          clr_en;
    logic [AW-1:0] clr_addr;

`ifdef SP_MEM_INIT_EN
    typedef enum logic [1:0] {
        INIT_IDLE  = 2'd0,
        INIT_CLEAR = 2'd1,
        INIT_DONE  = 2'd2
    } init_state_e;

    init_state_e   state;
    init_state_e   state_next;
    logic [AW-1:0] clr_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT_IDLE;
            clr_addr_q <= '0;
        end else begin
            state <= state_next;
            if (state == INIT_CLEAR) begin
                clr_addr_q <= clr_addr_q + AW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT_IDLE:  state_next = INIT_CLEAR;
            INIT_CLEAR: if (&clr_addr_q) state_next = INIT_DONE;
            default:    state_next = INIT_DONE;
        endcase
    end

    always_comb begin
        init_busy_o = (state != INIT_DONE);
        clr_en      = (state == INIT_CLEAR);
        clr_addr    = clr_addr_q;
    end
`else
    assign init_busy_o = 1'b0;
    assign clr_en      = 1'b0;
    assign clr_addr    = '0;
`endif

    // A grant needs a free slot counting both buffered and in-flight responses.
    assign fifo_nonempty = (occ != 2'd0);
    assign credit_ok     = ({1'b0, occ} + {2'b00, pending}) < 3'd2;
    assign grant         = bus.req & ~init_busy_o & credit_ok;
    assign bus.gnt       = grant;

    assign resp_data  = pend_rd ? mem_rdata_i : '0;
    assign bus.rvalid = fifo_nonempty | pending;
    assign bus.rdata  = fifo_nonempty ? fifo_q[rd_ptr] : (pending ? resp_data : '0);

    // The in-flight response bypasses the FIFO only when it is empty and the master takes it.
    assign fifo_pop  = fifo_nonempty & bus.rready;
    assign fifo_push = pending & (fifo_nonempty | ~bus.rready);

    always_comb begin
        mem_en_o    = grant;
        mem_we_o    = grant & bus.we;
        mem_addr_o  = bus.addr;
        mem_be_o    = bus.be;
        mem_wdata_o = bus.wdata;
        if (clr_en) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = clr_addr;
            mem_be_o    = {BW{1'b1}};
            mem_wdata_o = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            pend_rd <= 1'b0;
        end else begin
            pending <= grant;
            pend_rd <= grant & ~bus.we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_q[wr_ptr] <= resp_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

endmodule
